fft_8p_16b_loader: RTL and testbench

FFT_8P_16B_LOADER -- requirements
Module: fft_8p_16b_loader

---
 rtl/fft_8p_16b_loader_pkg.sv | 21 ++
 rtl/fft_8p_16b_loader_frame_bank.sv | 26 ++
 rtl/fft_8p_16b_loader.sv | 138 +++++++++++++
 tb/tb_fft_8p_16b_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_8p_16b_loader_pkg.sv
// Shared constants, sample/frame types and bank-state encoding for the
// 8-point FFT input loader.
package fft_pkg;

   localparam int FFT_N    = 8;
   localparam int SAMPLE_W = 32;
   localparam int COMP_W   = 16;
   localparam int IDX_W    = $clog2(FFT_N);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N - 1);

   typedef logic [SAMPLE_W-1:0] sample_t;
   typedef sample_t [FFT_N-1:0] frame_t;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_t;

endpackage

// File: rtl/fft_8p_16b_loader_frame_bank.sv
// One 8x32 sample bank: indexed single-sample write, whole frame visible
// in parallel on the read side.
module fft_frame_bank
   import fft_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  sample_t          wr_data,
   output frame_t           rd_frame
);

   frame_t mem;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_frame = mem;

endmodule

// File: rtl/fft_8p_16b_loader.sv
// Ping-pong loader that gathers a serial stream of complex samples into
// 8-sample frames and presents each frame in parallel to the FFT core.
module fft_8p_16b_loader
   import fft_pkg::*;
#(
   parameter int CHECK_LAST = 1
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_last,
   output logic [SAMPLE_W-1:0] xt0,
   output logic [SAMPLE_W-1:0] xt1,
   output logic [SAMPLE_W-1:0] xt2,
   output logic [SAMPLE_W-1:0] xt3,
   output logic [SAMPLE_W-1:0] xt4,
   output logic [SAMPLE_W-1:0] xt5,
   output logic [SAMPLE_W-1:0] xt6,
   output logic [SAMPLE_W-1:0] xt7,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                err_frame,
   input  logic                err_clr
);

   localparam bit CHK = (CHECK_LAST != 0);

   bank_state_t      state_q [2];
   bank_state_t      state_d [2];
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic             err_q, err_d;

   logic   xfer, consume, early_last, missing_last;
   logic   we0, we1;
   frame_t frame0, frame1, rd_frame;

   // Reset gates in_ready so nothing is accepted while the banks are cleared.
   assign in_ready     = rst_n && (state_q[wr_bank_q] != BANK_FULL);
   assign out_valid    = (state_q[rd_bank_q] == BANK_FULL);
   assign xfer         = in_valid && in_ready;
   assign consume      = out_valid && out_ready;
   assign early_last   = CHK && in_last && (wr_idx_q != LAST_IDX);
   assign missing_last = CHK && !in_last && (wr_idx_q == LAST_IDX);

   // A truncated frame never reaches the bank; its sample is simply dropped.
   assign we0 = xfer && !early_last && (wr_bank_q == 1'b0);
   assign we1 = xfer && !early_last && (wr_bank_q == 1'b1);

   // Read and write sides never touch the same bank on one edge: the write
   // bank is only the read bank while it is not FULL, so no consume there.
   always_comb begin
      state_d   = state_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_idx_d  = wr_idx_q;
      err_d     = err_q;

      if (consume) begin
         state_d[rd_bank_q] = BANK_EMPTY;
         rd_bank_d          = ~rd_bank_q;
      end

      if (err_clr) begin
         err_d = 1'b0;
      end

      if (xfer) begin
         if (early_last) begin
            state_d[wr_bank_q] = BANK_EMPTY;
            wr_idx_d           = '0;
            err_d              = 1'b1;
         end else if (wr_idx_q == LAST_IDX) begin
            state_d[wr_bank_q] = BANK_FULL;
            wr_bank_d          = ~wr_bank_q;
            wr_idx_d           = '0;
            if (missing_last) begin
               err_d = 1'b1;
            end
         end else begin
            state_d[wr_bank_q] = BANK_FILLING;
            wr_idx_d           = wr_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q[0] <= BANK_EMPTY;
         state_q[1] <= BANK_EMPTY;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_idx_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q[0] <= state_d[0];
         state_q[1] <= state_d[1];
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_idx_q   <= wr_idx_d;
         err_q      <= err_d;
      end
   end

   fft_frame_bank u_bank0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (we0),
      .wr_idx   (wr_idx_q),
      .wr_data  (in_data),
      .rd_frame (frame0)
   );

   fft_frame_bank u_bank1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (we1),
      .wr_idx   (wr_idx_q),
      .wr_data  (in_data),
      .rd_frame (frame1)
   );

   assign rd_frame  = rd_bank_q ? frame1 : frame0;
   assign xt0       = rd_frame[0];
   assign xt1       = rd_frame[1];
   assign xt2       = rd_frame[2];
   assign xt3       = rd_frame[3];
   assign xt4       = rd_frame[4];
   assign xt5       = rd_frame[5];
   assign xt6       = rd_frame[6];
   assign xt7       = rd_frame[7];
   assign err_frame = err_q;

endmodule

// File: tb/tb_fft_8p_16b_loader.sv
// Bench for fft_8p_16b_loader: table-driven stream scenarios plus hand-written
// backpressure, reset, error-clear and simultaneous-handover sequences.
module tb_fft_8p_16b_loader;
   import fft_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;
   logic        err_clr = 1'b0;
   logic        in_ready, out_valid, err_frame;
   logic [31:0] xt [8];
   logic        nc_in_ready, nc_out_valid, nc_err_frame;
   logic [31:0] nc_xt [8];

   int checks = 0;
   int failures = 0;
   int frames_seen = 0;
   int stalls = 0;

   typedef struct {
      logic [31:0] s [8];
   } frame_rec_t;

   frame_rec_t exp_q [$];
   frame_rec_t cur;
   int         model_idx = 0;
   logic       exp_err = 1'b0;

   typedef struct {
      int          n;
      logic [63:0] last_mask;
      logic        exp_err;
      int          exp_frames;
   } vec_t;

   vec_t vecs [5];

   always #5 clk = ~clk;

   fft_8p_16b_loader #(.CHECK_LAST(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .in_last(in_last),
      .xt0(xt[0]), .xt1(xt[1]), .xt2(xt[2]), .xt3(xt[3]),
      .xt4(xt[4]), .xt5(xt[5]), .xt6(xt[6]), .xt7(xt[7]),
      .out_valid(out_valid), .out_ready(out_ready),
      .err_frame(err_frame), .err_clr(err_clr)
   );

   fft_8p_16b_loader #(.CHECK_LAST(0)) dut_nc (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(nc_in_ready), .in_last(in_last),
      .xt0(nc_xt[0]), .xt1(nc_xt[1]), .xt2(nc_xt[2]), .xt3(nc_xt[3]),
      .xt4(nc_xt[4]), .xt5(nc_xt[5]), .xt6(nc_xt[6]), .xt7(nc_xt[7]),
      .out_valid(nc_out_valid), .out_ready(out_ready),
      .err_frame(nc_err_frame), .err_clr(err_clr)
   );

   function automatic void check_output(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endfunction

   // Reference framing model for the CHECK_LAST=1 instance.
   function automatic void model_accept(logic [31:0] d, logic l);
      if (l && model_idx != 7) begin
         model_idx = 0;
         exp_err   = 1'b1;
      end else begin
         cur.s[model_idx] = d;
         if (model_idx == 7) begin
            exp_q.push_back(cur);
            if (!l) exp_err = 1'b1;
            model_idx = 0;
         end else begin
            model_idx++;
         end
      end
   endfunction

   function automatic logic [31:0] gen(int vi, int i);
      if (vi == 0) return 32'((i + 1) << 16);
      return {16'(i + 1 + vi * 100), 16'(16'hFFFF - 16'(vi * 13 + i))};
   endfunction

   // Scoreboard: every presented frame is compared; a held frame must stay stable.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_frame out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         end else begin
            for (int k = 0; k < 8; k++)
               check_output($sformatf("xt%0d", k), xt[k], exp_q[0].s[k]);
            if (out_ready) begin
               void'(exp_q.pop_front());
               frames_seen++;
            end
         end
      end
   end

   task automatic apply_stimulus(input logic [31:0] d, input logic l, input int budget);
      bit done = 1'b0;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         else stalls++;
         @(posedge clk);
         #1;
         if (done) model_accept(d, l);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!done) check_output("send_timeout in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      err_clr  = 1'b0;
      @(negedge clk);
      check_output("reset in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      exp_q.delete();
      model_idx   = 0;
      exp_err     = 1'b0;
      frames_seen = 0;
      stalls      = 0;
      check_output("reset out_valid", 32'(out_valid), 32'd0);
      check_output("reset err_frame", 32'(err_frame), 32'd0);
      for (int k = 0; k < 8; k++)
         check_output($sformatf("reset xt%0d", k), xt[k], 32'd0);
      rst_n = 1'b1;
      #1;
      check_output("post_reset in_ready", 32'(in_ready), 32'd1);
      check_output("post_reset out_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) break;
      end
      @(posedge clk);
      #1;
      check_output("drain queue_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc;
      logic rdy;

      vecs[0] = '{n: 8,  last_mask: 64'h80,               exp_err: 1'b0, exp_frames: 1};
      vecs[1] = '{n: 8,  last_mask: 64'h0,                exp_err: 1'b1, exp_frames: 1};
      vecs[2] = '{n: 12, last_mask: 64'h808,              exp_err: 1'b1, exp_frames: 1};
      vecs[3] = '{n: 64, last_mask: 64'h8080808080808080, exp_err: 1'b0, exp_frames: 8};
      vecs[4] = '{n: 16, last_mask: 64'h80,               exp_err: 1'b1, exp_frames: 2};

      for (int vi = 0; vi < 5; vi++) begin
         do_reset();
         out_ready = 1'b1;
         for (int i = 0; i < vecs[vi].n; i++)
            apply_stimulus(gen(vi, i), vecs[vi].last_mask[i], 4);
         check_output($sformatf("v%0d latency out_valid", vi), 32'(out_valid), 32'd1);
         check_output($sformatf("v%0d stalls", vi), 32'(stalls), 32'd0);
         drain();
         check_output($sformatf("v%0d frames", vi), 32'(frames_seen), 32'(vecs[vi].exp_frames));
         check_output($sformatf("v%0d err_frame", vi), 32'(err_frame), 32'(vecs[vi].exp_err));
         check_output($sformatf("v%0d nc_err_frame", vi), 32'(nc_err_frame), 32'd0);
      end

      // Backpressure: 24 samples offered back to back with out_ready low.
      do_reset();
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 24; c++) begin
         in_data  = gen(5, acc);
         in_last  = (acc % 8 == 7);
         in_valid = 1'b1;
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            model_accept(gen(5, acc), (acc % 8 == 7));
            acc++;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_output("bp accepted", 32'(acc), 32'd16);
      check_output("bp in_ready", 32'(in_ready), 32'd0);
      check_output("bp out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      for (int i = acc; i < 24; i++)
         apply_stimulus(gen(5, i), (i % 8 == 7), 8);
      drain();
      check_output("bp frames", 32'(frames_seen), 32'd3);

      // Reset with a full frame pending and a partial one in progress.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 13; i++)
         apply_stimulus(gen(6, i), (i == 7), 4);
      check_output("rst pending out_valid", 32'(out_valid), 32'd1);
      do_reset();
      check_output("rst after xt0", xt[0], 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++)
         apply_stimulus(gen(7, i), (i == 7), 4);
      drain();
      check_output("rst frames", 32'(frames_seen), 32'd1);

      // Sticky error clear, and a new error on the clearing edge wins.
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++)
         apply_stimulus(gen(8, i), (i == 3), 4);
      check_output("err set", 32'(err_frame), 32'(exp_err));
      check_output("err no frame", 32'(out_valid), 32'd0);
      err_clr = 1'b1;
      exp_err = 1'b0;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check_output("err cleared", 32'(err_frame), 32'(exp_err));
      apply_stimulus(gen(8, 10), 1'b0, 4);
      apply_stimulus(gen(8, 11), 1'b0, 4);
      err_clr = 1'b1;
      exp_err = 1'b0;
      apply_stimulus(gen(8, 12), 1'b1, 4);
      err_clr = 1'b0;
      check_output("err clr_vs_new", 32'(err_frame), 32'(exp_err));
      check_output("err clr_vs_new no frame", 32'(out_valid), 32'd0);

      // Consumption of bank 0 and completion of bank 1 on the same edge.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 15; i++)
         apply_stimulus(gen(9, i), (i % 8 == 7), 4);
      out_ready = 1'b1;
      apply_stimulus(gen(9, 15), 1'b1, 4);
      check_output("sim frames_after_edge", 32'(frames_seen), 32'd1);
      check_output("sim out_valid", 32'(out_valid), 32'd1);
      check_output("sim in_ready", 32'(in_ready), 32'd1);
      drain();
      check_output("sim frames", 32'(frames_seen), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
